regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between the pipeline WB stage and a pipelined long-latency unit (LLU: multiply/divide).
- Holds a per-register busy scoreboard for LLU destinations and drives ID-stage stalls for RAW and WAW hazards against those destinations.
- Starvation guard: freezes the pipeline so a waiting LLU result can retire.
- Sits between the WB stage, the LLU result interface and the register file write port (rwW/RegWriteW/WBSrc).

Parameters:
- DATA_W, 32, datapath width
- MAX_OUT, 4, max LLU ops outstanding (issued, not yet written back)
- MAX_WAIT, 3, cycles an LLU result may wait before pipe_hold asserts

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, asynchronous, active-low
- wb_we  in  1  WB stage write enable
- wb_rd  in  5  WB destination
- wb_data  in  DATA_W  WB result
- llu_valid  in  1  LLU result valid
- llu_rd  in  5  LLU result destination
- llu_data  in  DATA_W  LLU result
- llu_ready  out  1  LLU result accepted this cycle
- id_rs, id_rt  in  5 each  ID source registers
- id_rs_used, id_rt_used  in  1 each  source actually read
- id_rd  in  5  ID destination
- id_we  in  1  ID instruction writes a register
- id_llu  in  1  ID instruction issues to the LLU
- id_issue  in  1  ID instruction leaves ID this cycle (pipeline-qualified)
- stall_id  out  1  hold ID; insert bubble into EX
- pipe_hold  out  1  freeze whole pipeline (starvation guard)
- rf_we  out  1  to regfile RegWriteW
- rf_rw  out  5  to regfile rwW
- rf_wdata  out  DATA_W  to regfile WBSrc

Behaviour:
- Reset (reset==0, async): busy[31:1]=0, out_cnt=0, wait_cnt=0, pipe_hold=0. Combinational outputs then follow inputs: stall_id=0 and llu_ready=1 when wb_we=0.
- Write-port arbitration (combinational, same cycle):
  - WB wins when wb_we=1 and wb_rd!=0.
  - Otherwise, if llu_valid=1, the LLU is granted: llu_ready=1, rf_we=(llu_rd!=0), rf_rw=llu_rd, rf_wdata=llu_data.
  - Otherwise rf_we=0, rf_rw=0, rf_wdata=0.
  - A WB write to r0 is dropped and does not block the LLU.
- Scoreboard:
  - On id_issue & id_llu & id_rd!=0: set busy[id_rd] and increment out_cnt.
  - On LLU grant: clear busy[llu_rd] and decrement out_cnt.
  - Set and clear of the same register in the same cycle: set wins. out_cnt is net unchanged.
  - busy[0] is always 0.
- stall_id is asserted when any of the following holds:
  - (id_rs_used & busy[id_rs]) or (id_rt_used & busy[id_rt]), with the register nonzero (RAW).
  - id_we & busy[id_rd], with id_rd nonzero (WAW).
  - id_llu & out_cnt==MAX_OUT.
- Registered bypass: a register cleared by a grant in cycle N is not busy in cycle N+1. There is no same-cycle bypass.
- Starvation FSM, states IDLE and HOLD:
  - wait_cnt increments each cycle llu_valid=1 and no grant occurs; it clears on grant or when llu_valid=0.
  - IDLE->HOLD when wait_cnt reaches MAX_WAIT-1 and the LLU is still denied. pipe_hold=1 from the next cycle.
  - Pipeline contract: while pipe_hold=1, wb_we is 0 from the cycle after assertion, so the LLU is granted.
  - HOLD->IDLE in the cycle after the grant. pipe_hold drops; wait_cnt=0.
- Reset mid-operation: all busy bits and counters clear immediately. Any in-flight LLU result is flushed by the LLU's own reset.
- The LLU is never back-pressured by out_cnt; only issue is limited.
- Underflow: a grant with out_cnt==0 is a protocol error. out_cnt saturates at 0 and a simulation-only assertion fires.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN
- With the macro defined:
  - Output stat_conflicts (16 bits): counts cycles with llu_valid=1 and no grant.
  - Output stat_holds (16 bits): counts IDLE->HOLD transitions.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Without the macro: neither port nor the counters exist. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0
  - arbiter state enum {ARB_IDLE, ARB_HOLD}
- Sub-module regfile_scoreboard holds the busy vector and out_cnt: set/clear ports, per-register query, count output.
- Arbitration mux and FSM stay in the top module.

Test Plan:
- Priority: wb_we=1, wb_rd=5 and llu_valid=1, llu_rd=9 in the same cycle -> rf_rw=5 and llu_ready=0. Next cycle, with wb_we=0 -> rf_rw=9 and llu_ready=1.
- RAW stall: issue LLU op with id_rd=8, then an ID instruction with id_rs=8 -> stall_id=1 until the cycle after the llu_rd=8 grant, then 0.
- WAW stall: busy[3]=1 and ID non-LLU instruction with id_rd=3, id_we=1 -> stall_id=1. Clear busy[3] -> stall_id=0 the next cycle.
- Outstanding limit: 4 LLU issues to r1..r4 -> out_cnt=4 and a 5th id_llu gives stall_id=1. One grant -> stall drops the next cycle.
- Starvation: llu_valid=1 with wb_we=1 every cycle, MAX_WAIT=3 -> pipe_hold=1 after 3 denied cycles. Bench drops wb_we -> grant, then pipe_hold=0 the following cycle.
- Reset mid-run: busy[7]=1, out_cnt=2, pipe_hold=1, pull reset low asynchronously -> all state 0 immediately and pipe_hold=0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file addressing and the write-port arbiter state encoding.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the pipeline (WB/ID), the LLU result port and the regfile write port.
interface regfile_wb_arbiter_if #(parameter int DATA_W = 32);
    import cpu_pkg::*;

    logic              wb_we;
    reg_addr_t         wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              llu_valid;
    reg_addr_t         llu_rd;
    logic [DATA_W-1:0] llu_data;
    logic              llu_ready;
    reg_addr_t         id_rs;
    reg_addr_t         id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    reg_addr_t         id_rd;
    logic              id_we;
    logic              id_llu;
    logic              id_issue;
    logic              stall_id;
    logic              pipe_hold;
    logic              rf_we;
    reg_addr_t         rf_rw;
    logic [DATA_W-1:0] rf_wdata;

    modport slave (
        input  wb_we, wb_rd, wb_data, llu_valid, llu_rd, llu_data,
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_llu, id_issue,
        output llu_ready, stall_id, pipe_hold, rf_we, rf_rw, rf_wdata
    );

    modport master (
        output wb_we, wb_rd, wb_data, llu_valid, llu_rd, llu_data,
        output id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_llu, id_issue,
        input  llu_ready, stall_id, pipe_hold, rf_we, rf_rw, rf_wdata
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per LLU destination register plus the count of LLU ops issued but not yet written back.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  reg_addr_t        set_rd,
    input  logic             clr_en,
    input  reg_addr_t        clr_rd,
    input  reg_addr_t [2:0]  q_addr,
    output logic      [2:0]  q_busy,
    output logic [CNT_W-1:0] out_cnt
);
    logic [NUM_REGS-1:0] busy, busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Clear first so that a same-cycle set of the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_rd] = 1'b0;
        if (set_en) busy_nxt[set_rd] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_comb begin
        cnt_nxt = out_cnt;
        if (set_en && !clr_en) begin
            if (out_cnt != CNT_W'(MAX_OUT)) cnt_nxt = out_cnt + CNT_W'(1);
        end else if (clr_en && !set_en) begin
            if (out_cnt != '0) cnt_nxt = out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= '0;
            out_cnt <= '0;
        end else begin
            busy    <= busy_nxt;
            out_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) q_busy[i] = busy[q_addr[i]];
    end

`ifndef SYNTHESIS
    // A write-back with nothing outstanding means the LLU and issue logic disagree.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(clr_en && !set_en && out_cnt == '0));
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: WB over LLU, LLU hazard stalls, starvation hold.
// Optional REGFILE_ARB_STATS_EN adds saturating conflict/hold counters.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_OUT  = 4,
    parameter int MAX_WAIT = 3
) (
    input logic clk,
    input logic reset,
    regfile_wb_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0] stat_conflicts,
    output logic [15:0] stat_holds
`endif
);
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              wb_win, grant, denied;
    logic              rf_we;
    reg_addr_t         rf_rw;
    logic [DATA_W-1:0] wdata;
    logic              set_en;
    logic [2:0]        q_busy;
    logic [CNT_W-1:0]  out_cnt;
    logic              raw_hit, waw_hit, lim_hit;
    arb_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              pipe_hold;

    // A WB write to r0 is discarded and leaves the port free for the LLU.
    assign wb_win        = bus.wb_we && (bus.wb_rd != REG_ZERO);
    assign grant         = bus.llu_valid && !wb_win;
    assign denied        = bus.llu_valid && wb_win;
    assign bus.llu_ready = !wb_win;

    always_comb begin
        rf_we = 1'b0;
        rf_rw = REG_ZERO;
        wdata = '0;
        if (wb_win) begin
            rf_we = 1'b1;
            rf_rw = bus.wb_rd;
            wdata = bus.wb_data;
        end else if (bus.llu_valid) begin
            rf_we = (bus.llu_rd != REG_ZERO);
            rf_rw = bus.llu_rd;
            wdata = bus.llu_data;
        end
    end

    assign bus.rf_we    = rf_we;
    assign bus.rf_rw    = rf_rw;
    assign bus.rf_wdata = wdata;

    assign set_en = bus.id_issue && bus.id_llu && (bus.id_rd != REG_ZERO);

    regfile_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_en),
        .set_rd  (bus.id_rd),
        .clr_en  (grant),
        .clr_rd  (bus.llu_rd),
        .q_addr  ({bus.id_rd, bus.id_rt, bus.id_rs}),
        .q_busy  (q_busy),
        .out_cnt (out_cnt)
    );

    // Busy bits are registered: a grant this cycle unblocks ID only next cycle.
    assign raw_hit = (bus.id_rs_used && (bus.id_rs != REG_ZERO) && q_busy[0])
                  || (bus.id_rt_used && (bus.id_rt != REG_ZERO) && q_busy[1]);
    assign waw_hit = bus.id_we && (bus.id_rd != REG_ZERO) && q_busy[2];
    assign lim_hit = bus.id_llu && (out_cnt == CNT_W'(MAX_OUT));
    assign bus.stall_id = raw_hit || waw_hit || lim_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        pipe_hold = 1'b0;
        if (denied)
            wait_nxt = (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + WAIT_W'(1);
        case (state)
            ARB_IDLE: if (denied && wait_cnt == WAIT_W'(MAX_WAIT - 1)) state_nxt = ARB_HOLD;
            ARB_HOLD: begin
                pipe_hold = 1'b1;
                if (grant) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign bus.pipe_hold = pipe_hold;

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_conflicts <= '0;
            stat_holds     <= '0;
        end else begin
            if (denied && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
            if (state == ARB_IDLE && state_nxt == ARB_HOLD && stat_holds != 16'hFFFF)
                stat_holds <= stat_holds + 16'd1;
        end
    end
`endif
endmodule
